// File: rtl/vga_pkg.sv
// Shared definitions for the VGA receive monitor: FSM state encoding, default
// 640x480@60 timing constants and CRC-16-CCITT constants.
package vga_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } rx_state_e;

   localparam int H_TOTAL_DEF     = 800;
   localparam int V_TOTAL_DEF     = 525;
   localparam int H_SYNC_DEF      = 96;
   localparam int V_SYNC_DEF      = 2;
   localparam int H_ACT_START_DEF = 144;
   localparam int V_ACT_START_DEF = 35;
   localparam int H_ACTIVE_DEF    = 640;
   localparam int V_ACTIVE_DEF    = 480;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // One 24-bit {R,G,B} word folded into the CRC, MSB first.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [23:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 23; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/vga_rx_axis.sv
// One timing axis of the VGA receiver: sync edge detect, position counter,
// sync low-width counter and period check. Used for both horizontal and vertical.
module vga_rx_axis #(
   parameter int TOTAL = 800,
   parameter int SYNC  = 96,
   parameter int W     = 10
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         sync_i,
   input  logic         step_i,
   output logic         fall_o,
   output logic [W-1:0] pos_o,
   output logic [W-1:0] len_o,
   output logic         len_bad_o,
   output logic         width_bad_o
);

   localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
   localparam logic [W-1:0] SYNC_W = W'(SYNC);

   logic         sync_q;
   logic         rise;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] wid_q, wid_d;
   logic [W-1:0] len_q, len_d;

   assign fall_o = sync_q & ~sync_i;
   assign rise   = ~sync_q & sync_i;

   always_comb begin
      cnt_d = cnt_q;
      wid_d = wid_q;
      len_d = len_q;
      if (fall_o) begin
         cnt_d = '0;
         wid_d = W'(1);
         len_d = cnt_q + 1'b1;
      end else begin
         if (step_i) cnt_d = cnt_q + 1'b1;
         if (!sync_i && step_i && wid_q != '1) wid_d = wid_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= 1'b0;
         cnt_q  <= '0;
         wid_q  <= '0;
         len_q  <= '0;
      end else begin
         sync_q <= sync_i;
         cnt_q  <= cnt_d;
         wid_q  <= wid_d;
         len_q  <= len_d;
      end
   end

   // pos_o is the position of the sample being taken this clock.
   assign pos_o       = cnt_d;
   assign len_o       = len_q;
   assign len_bad_o   = fall_o & (cnt_q != LAST);
   assign width_bad_o = rise & (wid_q != SYNC_W);

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA sink monitor: locks to HS/VS timing, rebuilds active coordinates, captures a
// probe pixel and counts timing errors. Optional frame CRC under VGA_RX_CRC_EN.
module vga_rx_monitor
   import vga_pkg::*;
#(
   parameter int H_TOTAL     = H_TOTAL_DEF,
   parameter int V_TOTAL     = V_TOTAL_DEF,
   parameter int H_SYNC      = H_SYNC_DEF,
   parameter int V_SYNC      = V_SYNC_DEF,
   parameter int H_ACT_START = H_ACT_START_DEF,
   parameter int V_ACT_START = V_ACT_START_DEF,
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF
) (
   input  logic        VGA_CLK,
   input  logic        reset,
   input  logic        VGA_HS,
   input  logic        VGA_VS,
   input  logic [7:0]  VGA_R,
   input  logic [7:0]  VGA_G,
   input  logic [7:0]  VGA_B,
   input  logic [9:0]  probe_x,
   input  logic [9:0]  probe_y,
   output logic        locked,
   output logic        rx_active,
   output logic [9:0]  rx_x,
   output logic [9:0]  rx_y,
   output logic [9:0]  line_len,
   output logic [9:0]  frame_lines,
   output logic [7:0]  probe_r,
   output logic [7:0]  probe_g,
   output logic [7:0]  probe_b,
   output logic        frame_done,
   output logic [7:0]  err_count,
   output logic [15:0] frame_crc
);

   localparam int               TO_W    = 12;
   localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(2 * H_TOTAL - 1);
   localparam logic [9:0]       HA0     = 10'(H_ACT_START);
   localparam logic [9:0]       HA1     = 10'(H_ACT_START + H_ACTIVE);
   localparam logic [9:0]       VA0     = 10'(V_ACT_START);
   localparam logic [9:0]       VA1     = 10'(V_ACT_START + V_ACTIVE);

   logic            h_fall, v_fall;
   logic            h_len_bad, v_len_bad, h_wid_bad, v_wid_bad;
   logic [9:0]      hpos, vpos;
   logic            sync_err, timeout, act, hit;
   logic [TO_W-1:0] to_q;

   rx_state_e       state_q;
   logic            frame_ok_q;
   logic [7:0]      err_q;

   logic            rx_active_q, frame_done_q, hit_q;
   logic [9:0]      rx_x_q, rx_y_q, px_q, py_q;
   logic [23:0]     hold_q, probe_q;

   vga_rx_axis #(.TOTAL(H_TOTAL), .SYNC(H_SYNC), .W(10)) u_h_axis (
      .clk_i       (VGA_CLK),
      .rst_i       (reset),
      .sync_i      (VGA_HS),
      .step_i      (1'b1),
      .fall_o      (h_fall),
      .pos_o       (hpos),
      .len_o       (line_len),
      .len_bad_o   (h_len_bad),
      .width_bad_o (h_wid_bad)
   );

   vga_rx_axis #(.TOTAL(V_TOTAL), .SYNC(V_SYNC), .W(10)) u_v_axis (
      .clk_i       (VGA_CLK),
      .rst_i       (reset),
      .sync_i      (VGA_VS),
      .step_i      (h_fall),
      .fall_o      (v_fall),
      .pos_o       (vpos),
      .len_o       (frame_lines),
      .len_bad_o   (v_len_bad),
      .width_bad_o (v_wid_bad)
   );

   assign sync_err = h_len_bad | v_len_bad | h_wid_bad | v_wid_bad;

   // Line-loss watchdog; parks at zero once expired until HS returns.
   always_ff @(posedge VGA_CLK or posedge reset) begin
      if (reset)            to_q <= '0;
      else if (h_fall)      to_q <= TO_LOAD;
      else if (to_q != '0)  to_q <= to_q - 1'b1;
   end

   assign timeout = (to_q == '0) & ~h_fall;

   always_ff @(posedge VGA_CLK or posedge reset) begin
      if (reset) begin
         state_q    <= SEARCH;
         frame_ok_q <= 1'b0;
         err_q      <= '0;
      end else if (timeout) begin
         state_q    <= SEARCH;
         frame_ok_q <= 1'b0;
      end else begin
         case (state_q)
            SEARCH: begin
               if (v_fall) begin
                  state_q    <= MEASURE;
                  frame_ok_q <= 1'b1;
               end
            end
            MEASURE: begin
               if (v_fall) begin
                  if (frame_ok_q && !sync_err) state_q <= LOCKED;
                  frame_ok_q <= 1'b1;
               end else if (sync_err) begin
                  frame_ok_q <= 1'b0;
               end
            end
            LOCKED: begin
               if (sync_err) begin
                  state_q    <= MEASURE;
                  // An error mid-frame spoils the frame in progress.
                  frame_ok_q <= v_fall;
                  if (err_q != 8'hFF) err_q <= err_q + 8'd1;
               end
            end
            default: state_q <= SEARCH;
         endcase
      end
   end

   assign locked    = (state_q == LOCKED);
   assign err_count = err_q;

   assign act = locked && (hpos >= HA0) && (hpos < HA1) && (vpos >= VA0) && (vpos < VA1);
   assign hit = act && ((hpos - HA0) == px_q) && ((vpos - VA0) == py_q);

   always_ff @(posedge VGA_CLK or posedge reset) begin
      if (reset) begin
         rx_active_q  <= 1'b0;
         rx_x_q       <= '0;
         rx_y_q       <= '0;
         frame_done_q <= 1'b0;
         px_q         <= '0;
         py_q         <= '0;
         hit_q        <= 1'b0;
         hold_q       <= '0;
         probe_q      <= '0;
      end else begin
         rx_active_q  <= act;
         rx_x_q       <= act ? hpos - HA0 : 10'd0;
         rx_y_q       <= act ? vpos - VA0 : 10'd0;
         frame_done_q <= v_fall;
         if (v_fall) begin
            px_q  <= probe_x;
            py_q  <= probe_y;
            hit_q <= 1'b0;
            if (hit_q) probe_q <= hold_q;
         end else if (hit) begin
            hold_q <= {VGA_R, VGA_G, VGA_B};
            hit_q  <= 1'b1;
         end
      end
   end

   assign rx_active  = rx_active_q;
   assign rx_x       = rx_x_q;
   assign rx_y       = rx_y_q;
   assign frame_done = frame_done_q;
   assign probe_r    = probe_q[23:16];
   assign probe_g    = probe_q[15:8];
   assign probe_b    = probe_q[7:0];

`ifdef VGA_RX_CRC_EN
   logic [15:0] crc_q, frame_crc_q;

   always_ff @(posedge VGA_CLK or posedge reset) begin
      if (reset) begin
         crc_q       <= CRC_INIT;
         frame_crc_q <= '0;
      end else if (v_fall) begin
         frame_crc_q <= crc_q;
         crc_q       <= CRC_INIT;
      end else if (act) begin
         crc_q <= crc16_step(crc_q, {VGA_R, VGA_G, VGA_B});
      end
   end

   assign frame_crc = frame_crc_q;
`else
   assign frame_crc = 16'h0000;
`endif

endmodule
